// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg
// Shared types for the counter_seq interval counter.
//   state_t : two-state FSM encoding (IDLE, RUN).
// Optional feature macro used by the design: COUNTER_SEQ_BUSY_EN.
package counter_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/counter_seq_if.sv
// counter_seq_if
// Control/status bundle of the counter_seq interval counter.
//   enable     : level gate, low forces the counter idle
//   start_strb : start / restart request
//   cntr       : current count value (dw bits)
//   strb       : one-cycle completion pulse
//   busy       : high while an interval runs (only with COUNTER_SEQ_BUSY_EN)
// Modports: master drives enable/start_strb, slave (the counter) drives
// cntr/strb/busy.
interface counter_seq_if #(
  parameter int dw = 8
);

  logic          enable;
  logic          start_strb;
  logic [dw-1:0] cntr;
  logic          strb;
`ifdef COUNTER_SEQ_BUSY_EN
  logic          busy;

  modport master (output enable, output start_strb,
                  input  cntr,   input  strb, input busy);
  modport slave  (input  enable, input  start_strb,
                  output cntr,   output strb, output busy);
`else
  modport master (output enable, output start_strb,
                  input  cntr,   input  strb);
  modport slave  (input  enable, input  start_strb,
                  output cntr,   output strb);
`endif

endinterface

// File: rtl/counter_seq.sv
// counter_seq
// One-shot interval counter. A start request launches a count from 0 up to
// `max`; one cycle after the terminal count is reached a single-cycle `strb`
// is emitted. Feeding strb back into start_strb gives a periodic tick with a
// period of max+2 clocks.
// Parameters:
//   dw  : counter width in bits
//   max : terminal count (dw bits, 0 allowed)
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : counter_seq_if.slave (enable, start_strb in; cntr, strb out)
// Optional feature: define COUNTER_SEQ_BUSY_EN to drive bus.busy, high while
// the FSM is in RUN.
module counter_seq
  import counter_seq_pkg::*;
#(
  parameter int            dw  = 8,
  parameter logic [dw-1:0] max = dw'(8'h7E)
) (
  input  logic          clk,
  input  logic          reset,
  counter_seq_if.slave  bus
);

  state_t        state_q, state_d;
  logic [dw-1:0] cntr_q,  cntr_d;
  logic          strb_q,  strb_d;

  always_comb begin
    state_d = state_q;
    cntr_d  = cntr_q;
    strb_d  = 1'b0;

    if (!bus.enable) begin
      // Dropping enable abandons any interval in flight and masks starts.
      state_d = IDLE;
      cntr_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cntr_d = '0;
          if (bus.start_strb) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (bus.start_strb) begin
            // Restart wins over terminal count: the aborted interval
            // produces no strobe.
            cntr_d = '0;
          end else if (cntr_q == max) begin
            state_d = IDLE;
            cntr_d  = '0;
            strb_d  = 1'b1;
          end else begin
            cntr_d = cntr_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cntr_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cntr_q  <= '0;
      strb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cntr_q  <= cntr_d;
      strb_q  <= strb_d;
    end
  end

  assign bus.cntr = cntr_q;
  assign bus.strb = strb_q;

`ifdef COUNTER_SEQ_BUSY_EN
  assign bus.busy = (state_q == RUN);
`endif

endmodule

// File: tb/tb_counter_seq.sv
// tb_counter_seq
// Directed bench for counter_seq. Five instances with different dw/max share
// one clock and reset; each scenario drives its own instance.
//   u_a : dw=8, max=0x7E  (reset mid-count)
//   u_b : dw=4, max=2     (one-shot)
//   u_c : dw=8, max=0x0E  (self-retrigger, period 16)
//   u_d : dw=8, max=0     (self-retrigger, period 2)
//   u_e : dw=8, max=6     (restart, enable drop)
// Busy checks are compiled in when COUNTER_SEQ_BUSY_EN is defined.
module tb_counter_seq;

  logic clk;
  logic reset;
  logic kick_c;
  logic kick_d;

  int errors;
  int checks;

  int exp_cntr_b [5] = '{0, 1, 2, 0, 0};
  int exp_strb_b [5] = '{0, 0, 0, 1, 0};
  int exp_busy_b [5] = '{1, 1, 1, 0, 0};

  counter_seq_if #(.dw(8)) if_a ();
  counter_seq_if #(.dw(4)) if_b ();
  counter_seq_if #(.dw(8)) if_c ();
  counter_seq_if #(.dw(8)) if_d ();
  counter_seq_if #(.dw(8)) if_e ();

  // Self-retrigger loops: strobe fed back, OR'ed with a one-off kick.
  assign if_c.start_strb = if_c.strb | kick_c;
  assign if_d.start_strb = if_d.strb | kick_d;

  counter_seq #(.dw(8), .max(8'h7E)) u_a (.clk(clk), .reset(reset), .bus(if_a));
  counter_seq #(.dw(4), .max(4'h2))  u_b (.clk(clk), .reset(reset), .bus(if_b));
  counter_seq #(.dw(8), .max(8'h0E)) u_c (.clk(clk), .reset(reset), .bus(if_c));
  counter_seq #(.dw(8), .max(8'h00)) u_d (.clk(clk), .reset(reset), .bus(if_d));
  counter_seq #(.dw(8), .max(8'h06)) u_e (.clk(clk), .reset(reset), .bus(if_e));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    kick_c = 1'b0;
    kick_d = 1'b0;
    if_a.enable = 1'b0; if_a.start_strb = 1'b0;
    if_b.enable = 1'b0; if_b.start_strb = 1'b0;
    if_c.enable = 1'b0;
    if_d.enable = 1'b0;
    if_e.enable = 1'b0; if_e.start_strb = 1'b0;

    // ---- reset state ----
    tick(2);
    chk("reset_cntr", 32'(if_a.cntr), 0);
    chk("reset_strb", 32'(if_a.strb), 0);
`ifdef COUNTER_SEQ_BUSY_EN
    chk("reset_busy", 32'(if_a.busy), 0);
`endif
    reset = 1'b0;
    $display("reset released, idle state checked");

    // ---- one-shot, dw=4 max=2 ----
    if_b.enable = 1'b1;
    if_b.start_strb = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      if_b.start_strb = 1'b0;
      chk($sformatf("oneshot_cntr[%0d]", k), 32'(if_b.cntr), exp_cntr_b[k]);
      chk($sformatf("oneshot_strb[%0d]", k), 32'(if_b.strb), exp_strb_b[k]);
`ifdef COUNTER_SEQ_BUSY_EN
      chk($sformatf("oneshot_busy[%0d]", k), 32'(if_b.busy), exp_busy_b[k]);
`endif
    end
    $display("one-shot max=2 sequence checked");

    // ---- restart, max=6: second start 3 edges after the first ----
    if_e.enable = 1'b1;
    if_e.start_strb = 1'b1;
    tick(1);
    if_e.start_strb = 1'b0;
    tick(2);
    chk("restart_pre_cntr", 32'(if_e.cntr), 2);
    if_e.start_strb = 1'b1;
    tick(1);
    if_e.start_strb = 1'b0;
    chk("restart_reload_cntr", 32'(if_e.cntr), 0);
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      chk($sformatf("restart_cntr[%0d]", k), 32'(if_e.cntr), (k <= 6) ? k : 0);
      chk($sformatf("restart_strb[%0d]", k), 32'(if_e.strb), (k == 7) ? 1 : 0);
    end
    $display("restart max=6 checked");

    // ---- enable drop, max=6 ----
    if_e.start_strb = 1'b1;
    tick(1);
    if_e.start_strb = 1'b0;
    tick(3);
    chk("endrop_pre_cntr", 32'(if_e.cntr), 3);
    if_e.enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if_e.start_strb = (k == 1 || k == 3) ? 1'b1 : 1'b0;
      tick(1);
      chk($sformatf("endrop_low_cntr[%0d]", k), 32'(if_e.cntr), 0);
      chk($sformatf("endrop_low_strb[%0d]", k), 32'(if_e.strb), 0);
    end
    if_e.start_strb = 1'b0;
    if_e.enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk($sformatf("endrop_idle_cntr[%0d]", k), 32'(if_e.cntr), 0);
      chk($sformatf("endrop_idle_strb[%0d]", k), 32'(if_e.strb), 0);
    end
    if_e.start_strb = 1'b1;
    tick(1);
    if_e.start_strb = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      chk($sformatf("endrop_fresh_strb[%0d]", k), 32'(if_e.strb), (k == 7) ? 1 : 0);
    end
    $display("enable drop checked");

    // ---- self-retrigger, max=0x0E, period 16 over 10 periods ----
    if_c.enable = 1'b1;
    kick_c = 1'b1;
    tick(1);
    kick_c = 1'b0;
    for (int k = 1; k <= 160; k++) begin
      tick(1);
      chk($sformatf("retrig16_strb[%0d]", k), 32'(if_c.strb), ((k % 16) == 15) ? 1 : 0);
    end
    $display("self-retrigger max=0x0E checked");

    // ---- self-retrigger, max=0, period 2 ----
    if_d.enable = 1'b1;
    kick_d = 1'b1;
    tick(1);
    kick_d = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      chk($sformatf("retrig2_strb[%0d]", k), 32'(if_d.strb), ((k % 2) == 1) ? 1 : 0);
    end
    $display("self-retrigger max=0 checked");

    // ---- reset mid-count, max=0x7E ----
    if_a.enable = 1'b1;
    if_a.start_strb = 1'b1;
    tick(1);
    if_a.start_strb = 1'b0;
    tick(40);
    chk("midreset_pre_cntr", 32'(if_a.cntr), 40);
`ifdef COUNTER_SEQ_BUSY_EN
    chk("midreset_pre_busy", 32'(if_a.busy), 1);
`endif
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_async_cntr", 32'(if_a.cntr), 0);
    chk("midreset_async_strb", 32'(if_a.strb), 0);
`ifdef COUNTER_SEQ_BUSY_EN
    chk("midreset_async_busy", 32'(if_a.busy), 0);
`endif
    tick(1);
    reset = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick(1);
      chk($sformatf("midreset_after_strb[%0d]", k), 32'(if_a.strb), 0);
      chk($sformatf("midreset_after_cntr[%0d]", k), 32'(if_a.cntr), 0);
    end
    $display("reset mid-count checked");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
